rr_arb_4_to_mux: RTL and testbench

Four-channel round-robin arbiter with a one-entry output register that produces the 2-bit select and 4-bit data word consumed by the downstream `mux_4_1` datapath stage. It accepts valid/ready traffic on four 4-bit input channels, picks one channel per transfer in rotating priority, and presents the winner's data together with its channel index. The block sits directly upstream of the 4:1 mux and is its only source of `sel`.

---
 rtl/rr_arb_pkg.sv | 29 ++
 rtl/rr_arb_4_to_mux_if.sv | 36 +++
 rtl/mux_4_1.sv | 31 +++
 rtl/rr_pick4.sv | 41 ++++
 rtl/rr_arb_4_to_mux.sv | 102 ++++++++++
 tb/tb_rr_arb_4_to_mux.sv | 179 +++++++++++++++++
 6 files changed

// File: rtl/rr_arb_pkg.sv
// ============================================================================
//  Module   : rr_arb_pkg
//  Brief    : Shared widths, types and helpers for the 4-channel RR arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rr_arb_pkg;

  localparam int N_CH   = 4;
  localparam int SEL_W  = 2;
  localparam int DATA_W = 4;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_t;

  // Modulo-4 increment; the 2-bit result wraps 3 -> 0 naturally.
  function automatic sel_t sel_inc(input sel_t s);
    return s + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb_4_to_mux_if.sv
// ============================================================================
//  Module   : rr_arb_4_to_mux_if
//  Brief    : Input channels and output word handshake of the RR arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface rr_arb_4_to_mux_if;
  import rr_arb_pkg::*;

  logic [N_CH-1:0] in_valid;
  data_t           in_data0;
  data_t           in_data1;
  data_t           in_data2;
  data_t           in_data3;
  logic [N_CH-1:0] in_ready;
  logic            out_valid;
  logic            out_ready;
  data_t           out_data;
  sel_t            out_sel;

  // master: traffic source and sink around the arbiter
  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // slave: the arbiter itself
  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

`default_nettype wire

// File: rtl/mux_4_1.sv
// ============================================================================
//  Module   : mux_4_1
//  Brief    : 4:1 data multiplexer of the downstream datapath stage.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_4_1
  import rr_arb_pkg::*;
(
  input  wire sel_t  sel,
  input  wire data_t d0,
  input  wire data_t d1,
  input  wire data_t d2,
  input  wire data_t d3,
  output      data_t y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rr_pick4.sv
// ============================================================================
//  Module   : rr_pick4
//  Brief    : Combinational rotating-priority pick of the first request at or
//             after ptr.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick4
  import rr_arb_pkg::*;
(
  input  wire logic [N_CH-1:0] req,
  input  wire sel_t            ptr,
  output      sel_t            g,
  output      logic            any
);

  logic [N_CH-1:0] w_rot;
  sel_t            w_off;

  // Rotate so that bit 0 of w_rot is the channel at ptr.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_rot[i] = req[sel_t'(i) + ptr];
    end
  end

  always_comb begin
    w_off = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = sel_t'(i);
    end
  end

  assign g   = ptr + w_off;
  assign any = |req;

endmodule

`default_nettype wire

// File: rtl/rr_arb_4_to_mux.sv
// ============================================================================
//  Module   : rr_arb_4_to_mux
//  Brief    : 4-channel round-robin arbiter with a one-entry output register
//             feeding sel/data of the downstream mux_4_1 stage.
//             Optional saturating grant counter: define RR_ARB_GRANT_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb_4_to_mux
  import rr_arb_pkg::*;
#(
  parameter int PTR_INIT = 0,
  parameter int CNT_W    = 8
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  rr_arb_4_to_mux_if.slave bus
`ifdef RR_ARB_GRANT_CNT_EN
  ,
  output      logic [CNT_W-1:0] grant_cnt
`endif
);

  generate
    if (PTR_INIT < 0 || PTR_INIT > 3 || CNT_W < 1) begin : g_param_check
      $error("rr_arb_4_to_mux: PTR_INIT must be 0..3 and CNT_W >= 1");
    end
  endgenerate

  ostate_t r_state;
  data_t   r_data;
  sel_t    r_sel;
  sel_t    r_ptr;

  logic    w_load;
  logic    w_any;
  logic    w_accept;
  sel_t    w_g;
  data_t   w_mux;

  assign bus.out_valid = (r_state == ST_FULL);
  assign bus.out_data  = r_data;
  assign bus.out_sel   = r_sel;

  assign w_load   = !bus.out_valid || bus.out_ready;
  // Gating with rst_n keeps the reset cycle free of completed handshakes.
  assign w_accept = rst_n && w_load && w_any;

  rr_pick4 u_pick (
    .req (bus.in_valid),
    .ptr (r_ptr),
    .g   (w_g),
    .any (w_any)
  );

  mux_4_1 u_mux (
    .sel (w_g),
    .d0  (bus.in_data0),
    .d1  (bus.in_data1),
    .d2  (bus.in_data2),
    .d3  (bus.in_data3),
    .y   (w_mux)
  );

  assign bus.in_ready = w_accept ? (4'b0001 << w_g) : 4'b0000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= sel_t'(PTR_INIT);
    end else if (w_load) begin
      if (w_any) begin
        r_state <= ST_FULL;
        r_data  <= w_mux;
        r_sel   <= w_g;
        r_ptr   <= sel_inc(w_g);
      end else begin
        r_state <= ST_EMPTY;
      end
    end
  end

`ifdef RR_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] r_grant_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant_cnt <= '0;
    end else if (w_accept && (r_grant_cnt != {CNT_W{1'b1}})) begin
      r_grant_cnt <= r_grant_cnt + 1'b1;
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_4_to_mux.sv
// ============================================================================
//  Module   : tb_rr_arb_4_to_mux
//  Brief    : Directed bench for rr_arb_4_to_mux with a reference model and
//             an output-word scoreboard. Honours RR_ARB_GRANT_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_arb_4_to_mux;
  import rr_arb_pkg::*;

  localparam int PTR_INIT = 0;
  localparam int CNT_W    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_arb_4_to_mux_if bus ();

  data_t dat [4];
  assign bus.in_data0 = dat[0];
  assign bus.in_data1 = dat[1];
  assign bus.in_data2 = dat[2];
  assign bus.in_data3 = dat[3];

`ifdef RR_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] grant_cnt;
`endif

  rr_arb_4_to_mux #(
    .PTR_INIT (PTR_INIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef RR_ARB_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int         m_ptr   = PTR_INIT;
  bit         m_valid = 1'b0;
  int         m_cnt   = 0;
  logic [5:0] q [$];

  function automatic int pick(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock with the currently driven inputs; checks before and after the edge.
  task automatic cycle();
    int         g;
    bit         load;
    bit         rst_at_edge;
    logic [3:0] exp_rdy;
    logic [1:0] gs;
    #1;
    load    = !m_valid || bus.out_ready;
    g       = pick(bus.in_valid, m_ptr);
    exp_rdy = (rst_n && load && g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    rst_at_edge = !rst_n;
    @(posedge clk);
    if (rst_at_edge) begin
      m_valid = 1'b0;
      m_ptr   = PTR_INIT;
      m_cnt   = 0;
      q.delete();
    end else begin
      if (m_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
      if (load) begin
        if (g >= 0) begin
          gs = 2'(g);
          q.push_back({gs, dat[g]});
          m_valid = 1'b1;
          m_ptr   = (g + 1) % 4;
          m_cnt   = (m_cnt < (2**CNT_W - 1)) ? m_cnt + 1 : m_cnt;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (rst_at_edge) begin
      chk("rst_out_sel", 32'(bus.out_sel), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
    end else if (m_valid) begin
      if (q.size() > 0) chk("out_word", 32'({bus.out_sel, bus.out_data}), 32'(q[0]));
      else chk("scoreboard_empty", 32'(q.size()), 32'd1);
    end
`ifdef RR_ARB_GRANT_CNT_EN
    chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
`endif
  endtask

  initial begin
    dat[0] = 4'hA; dat[1] = 4'hB; dat[2] = 4'hC; dat[3] = 4'hD;
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    cycle();
    bus.in_valid = 4'b1111;       // in_ready must stay 0 while in reset
    cycle();
    rst_n = 1'b1;

    // full rotation: 0,1,2,3,0 with data A,B,C,D,A
    repeat (5) cycle();
    bus.in_valid = 4'b0000;
    cycle();                      // drains to EMPTY

    // single requester on channel 2
    dat[2] = 4'h5;
    bus.in_valid = 4'b0100;
    cycle();
    bus.in_valid = 4'b0000;
    cycle();

    // backpressure holding word 7 while channels 0 and 1 wait
    dat[0] = 4'h7;
    bus.in_valid = 4'b0001;
    cycle();
    bus.out_ready = 1'b0;
    dat[0] = 4'h1; dat[1] = 4'h2;
    bus.in_valid = 4'b0011;
    repeat (5) cycle();
    bus.out_ready = 1'b1;
    cycle();
    cycle();

    // wrap-around: last grant 3, then channels 1 and 3
    bus.in_valid = 4'b1000;
    cycle();
    dat[1] = 4'h9; dat[3] = 4'hE;
    bus.in_valid = 4'b1010;
    cycle();
    cycle();
    bus.in_valid = 4'b0000;
    cycle();

    // reset while a word is held
    bus.in_valid = 4'b0100;
    cycle();
    bus.in_valid  = 4'b0011;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    dat[0] = 4'h3; dat[1] = 4'h4; dat[2] = 4'h6; dat[3] = 4'h8;
    bus.in_valid = 4'b1111;
    repeat (5) cycle();           // restarts at PTR_INIT; counter saturates
    bus.in_valid = 4'b0000;
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
